// File: rtl/num_to_barcode_converter.sv
// rtl/num_to_barcode_converter.sv - 4-bit number to 11-bit guarded Manchester barcode, one registered stage.
// Optional decode/self-check outputs are enabled by defining NUM_TO_BC_SELFCHECK_EN.
module num_to_barcode_converter #(
    parameter logic [1:0] START_GUARD = 2'b10,
    parameter logic       STOP_BAR    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  num,
`ifdef NUM_TO_BC_SELFCHECK_EN
    output logic [3:0]  dec_num,
    output logic [0:0]  dec_err,
`endif
    output logic [10:0] bc,
    output logic        out_valid
);

    // num[i] occupies payload pair [2i+1:2i], i.e. bc[2i+2:2i+1]; MSB lands nearest the start guard
    function automatic logic [10:0] encode(input logic [3:0] n);
        logic [7:0] payload;
        payload = '0;
        for (int i = 0; i < 4; i++) begin
            payload[2*i +: 2] = n[i] ? 2'b10 : 2'b01;
        end
        return {START_GUARD, payload, STOP_BAR};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bc        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                bc <= encode(num);
            end
        end
    end

`ifdef NUM_TO_BC_SELFCHECK_EN
    logic pair_err;

    always_comb begin
        dec_num  = '0;
        pair_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dec_num[i] = bc[2*i+2];
            if (bc[2*i+2] == bc[2*i+1]) begin
                pair_err = 1'b1;
            end
        end
        dec_err[0] = out_valid & (pair_err | (bc[10:9] != START_GUARD) | (bc[0] != STOP_BAR));
    end
`endif

endmodule

// File: tb/tb_num_to_barcode_converter.sv
// tb/tb_num_to_barcode_converter.sv - self-checking bench for num_to_barcode_converter.
// Decode outputs are checked when NUM_TO_BC_SELFCHECK_EN is defined.
module tb_num_to_barcode_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  num;
    logic [10:0] bc;
    logic        out_valid;
`ifdef NUM_TO_BC_SELFCHECK_EN
    logic [3:0]  dec_num;
    logic [0:0]  dec_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    num_to_barcode_converter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num       (num),
`ifdef NUM_TO_BC_SELFCHECK_EN
        .dec_num   (dec_num),
        .dec_err   (dec_err),
`endif
        .bc        (bc),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: barcode as a number = guard*2^9 + manchester*2 + stop, manchester built base-4 MSB first
    function automatic logic [10:0] model_code(input logic [3:0] n);
        int m;
        m = 0;
        for (int i = 3; i >= 0; i--) begin
            m = m * 4 + (n[i] ? 2 : 1);
        end
        return 11'(2 * 512 + m * 2 + 1);
    endfunction

    logic [10:0] exp_bc    = '0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_num   = '0;
    logic        check_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_bc    = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_bc  = model_code(num);
                exp_num = num;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_checks++;
            if (bc !== exp_bc || out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t bc=%b out_valid=%b required bc=%b out_valid=%b",
                         $time, bc, out_valid, exp_bc, exp_valid);
            end
`ifdef NUM_TO_BC_SELFCHECK_EN
            n_checks++;
            if (dec_err !== 1'b0) begin
                n_fail++;
                $display("FAIL dec_err t=%0t actual=%b required=0", $time, dec_err);
            end
            if (exp_bc != 11'd0) begin
                n_checks++;
                if (dec_num !== exp_num) begin
                    n_fail++;
                    $display("FAIL dec_num t=%0t actual=%h required=%h", $time, dec_num, exp_num);
                end
            end
`endif
        end
    end

    // Inputs change on the falling edge; outputs are read after the following falling edge
    task automatic step(input logic r, input logic v, input logic [3:0] n);
        rst      = r;
        in_valid = v;
        num      = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [10:0] exp_b, input logic exp_v);
        n_checks++;
        if (bc !== exp_b || out_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s bc=%b out_valid=%b required bc=%b out_valid=%b",
                     name, bc, out_valid, exp_b, exp_v);
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0; num = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;

        // 1: reset, then first accepted input
        step(1'b1, 1'b1, 4'h0);
        check_lit("reset_hold", 11'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0000);
        check_lit("num_0000", 11'b10010101011, 1'b1);

        // 2: back-to-back
        step(1'b0, 1'b1, 4'b0101);
        check_lit("num_0101", 11'b10011001101, 1'b1);
        step(1'b0, 1'b1, 4'b1010);
        check_lit("num_1010", 11'b10100110011, 1'b1);
        step(1'b0, 1'b1, 4'b1111);
        check_lit("num_1111", 11'b10101010101, 1'b1);

        // 3: sweep with in_valid every third cycle
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 4'(k));
            if (out_valid) pulses++;
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 1'b0, 4'(15 - k));
                if (out_valid) pulses++;
            end
        end
        n_checks++;
        if (pulses != 16) begin
            n_fail++;
            $display("FAIL sweep_pulses actual=%0d required=16", pulses);
        end
        check_lit("sweep_last", 11'b10101010101, 1'b0);

        // 4: hold when in_valid drops
        step(1'b0, 1'b1, 4'b0011);
        check_lit("num_0011", 11'b10010110101, 1'b1);
        step(1'b0, 1'b0, 4'b1100);
        check_lit("hold_0011", 11'b10010110101, 1'b0);
        step(1'b0, 1'b0, 4'b1100);
        check_lit("hold_0011_b", 11'b10010110101, 1'b0);

        // 5: reset beats in_valid and discards the input
        step(1'b1, 1'b1, 4'b1001);
        check_lit("rst_vs_valid", 11'b0, 1'b0);
        step(1'b0, 1'b0, 4'b1001);
        check_lit("rst_discard", 11'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0110);
        check_lit("rst_discard_b", 11'b0, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 4'($urandom));
        end

        // Pin the model to literal codes
        n_checks++;
        if (model_code(4'b1001) != 11'b10100101101) begin
            n_fail++;
            $display("FAIL model_pin actual=%b required=%b", model_code(4'b1001), 11'b10100101101);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/num_to_barcode_converter.md
Name: num_to_barcode_converter

Overview:
Converts a 4-bit number into an 11-bit barcode word made of a start guard, a Manchester-coded payload and a stop bar. The block is a single registered stage: the input is sampled on an input-valid strobe, and the result appears one clock later with an output-valid flag. It sits between a numeric source and a barcode rendering or serialising stage, and is exercised exhaustively over all 16 inputs.

Parameters:
START_GUARD, 2'b10, start-guard pattern placed in bc[10:9].
STOP_BAR, 1'b1, stop-bar value placed in bc[0].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  sample num this cycle.
num  input  4  number to encode; num[3] is the MSB.
bc  output  11  registered barcode word.
out_valid  output  1  bc was updated at this edge; high for one cycle per accepted input.

Behaviour:
- Encoding, all bit-exact:
  - bc[10:9] = START_GUARD.
  - bc[8:1] = Manchester code of num, MSB first.
  - Each num bit maps to 2 bits: 1 -> 2'b10, 0 -> 2'b01.
  - Mapping: num[3] -> bc[8:7], num[2] -> bc[6:5], num[1] -> bc[4:3], num[0] -> bc[2:1].
  - bc[0] = STOP_BAR.
- Latency is 1 cycle. If in_valid=1 at edge N, then from edge N onward bc = encode(num) and out_valid=1.
- If in_valid=0 at an edge, bc holds its previous value and out_valid=0.
- Back-to-back inputs: every cycle with in_valid=1 is accepted. There is no backpressure and no ready signal.
- Reset:
  - If rst=1 at an edge, then bc = 11'b0 and out_valid = 0.
  - Reset has priority over in_valid.
  - Reset mid-stream discards the input sampled in that cycle.
- After reset, bc stays all-zero until the first accepted input. All-zero is never a legal code, because the guards are nonzero.
- num is always a legal input; every 4-bit value has a defined code.
- No X propagation: with rst asserted, outputs are defined regardless of num and in_valid.

Optional Feature:
Macro: NUM_TO_BC_SELFCHECK_EN.
- When defined, two extra outputs are added:
  - dec_num [3:0]: combinational decode of the registered bc.
  - dec_err [0:0]: high when bc is invalid, i.e. when any of the following holds:
    - bc[10:9] differs from START_GUARD;
    - bc[0] differs from STOP_BAR;
    - any Manchester pair is 2'b00 or 2'b11.
- dec_err is qualified by out_valid: it is forced to 0 when out_valid=0.
- The decode rule for each Manchester pair is: 2'b10 -> 1, 2'b01 -> 0.
- When the macro is not defined, these ports and their logic do not exist. The behaviour of the other ports is identical in both builds.

Test Plan:
1. Hold rst=1 for 2 clocks, then drive in_valid=1 with num=4'b0000. Required: bc=0 and out_valid=0 while in reset; one edge later, bc=11'b10010101011 and out_valid=1.
2. Drive num=4'b0101, then 4'b1010, then 4'b1111 on consecutive cycles with in_valid=1. Required:
   - bc=11'b10011001101 after the first edge;
   - bc=11'b10100110011 after the second edge;
   - bc=11'b10101010101 after the third edge;
   - out_valid stays 1 throughout.
3. Sweep num from 0 to 15, with in_valid pulsed once every 3 cycles. Required:
   - each bc equals the guard, Manchester and stop formula;
   - out_valid pulses once per input;
   - bc holds its value between pulses.
4. Accept num=4'b0011 (bc=11'b10010110101), then drop in_valid and change num to 4'b1100. Required: bc stays 11'b10010110101 and out_valid=0.
5. Assert rst=1 in the same cycle as in_valid=1 with num=4'b1001. Required: bc=0 and out_valid=0 at that edge; the input is not reflected later.
6. Build with NUM_TO_BC_SELFCHECK_EN and sweep all 16 inputs. Required: dec_num equals the accepted num, and dec_err=0. Also required: dec_err=0 while out_valid=0 after reset.
